password_access_ctrl: RTL and testbench

- Sequences the password datapath for one board.
- Holds the master password, set from the digit-select front end.
- Verifies submitted 4-digit guesses against it and counts failed attempts.
- After MAX_ATTEMPTS consecutive failures, enforces a timed lockout.
- Sits between the password digit-entry logic (selected_password / button or mouse confirm) and the top-level phase FSM and seven-segment status display.

---
 rtl/password_access_ctrl_if.sv | 28 ++
 rtl/password_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_password_access_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/password_access_ctrl_if.sv
// Interface for password_access_ctrl: the command pulses and data from the
// digit-entry front end, plus the status outputs that go to the phase FSM and display.
interface password_access_ctrl_if;
    logic        set_pw;
    logic [13:0] new_password;
    logic        submit;
    logic [13:0] guess;
    logic        logout;
    logic [2:0]  state;
    logic        unlocked;
    logic        denied;
    logic        locked;
    logic [2:0]  attempts_left;
    logic [7:0]  lockout_remaining;
    logic        pw_valid;

    // Front end and phase FSM side
    modport master (
        output set_pw, new_password, submit, guess, logout,
        input  state, unlocked, denied, locked, attempts_left, lockout_remaining, pw_valid
    );

    // Access controller side
    modport slave (
        input  set_pw, new_password, submit, guess, logout,
        output state, unlocked, denied, locked, attempts_left, lockout_remaining, pw_valid
    );
endinterface

// File: rtl/password_access_ctrl.sv
// Password access controller: holds the master password, checks 4-digit
// guesses, counts failed attempts and enforces a timed lockout.
module password_access_ctrl #(
    parameter int unsigned MAX_ATTEMPTS  = 3,
    parameter int unsigned LOCKOUT_SEC   = 10,
    parameter int unsigned TICKS_PER_SEC = 100000000,
    parameter int unsigned DEFAULT_PW    = 0
) (
    input  logic                  basys_clk,
    input  logic                  reset,
    password_access_ctrl_if.slave bus
);

    localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [13:0] PW_MAX  = 14'd9999;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        GRANTED = 3'd2,
        LOCKOUT = 3'd3
    } state_t;

    state_t              state_q, state_d;
    logic [13:0]         master_q, master_d;
    logic [13:0]         guess_q, guess_d;
    logic                pw_valid_q, pw_valid_d;
    logic [2:0]          attempts_q, attempts_d;
    logic [7:0]          lockout_q, lockout_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                unlocked_q, unlocked_d;
    logic                denied_q, denied_d;
    logic                locked_q, locked_d;

    // Next-state and next-output computation for the access FSM
    always_comb begin
        state_d    = state_q;
        master_d   = master_q;
        guess_d    = guess_q;
        pw_valid_d = pw_valid_q;
        attempts_d = attempts_q;
        lockout_d  = lockout_q;
        presc_d    = '0;
        denied_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // set_pw has priority: a coincident submit is dropped even if
                // the set itself is refused because a password already exists.
                if (bus.set_pw) begin
                    if (!pw_valid_q && bus.new_password <= PW_MAX) begin
                        master_d   = bus.new_password;
                        pw_valid_d = 1'b1;
                    end
                end else if (bus.submit && pw_valid_q) begin
                    guess_d = bus.guess;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (guess_q <= PW_MAX && guess_q == master_q) begin
                    state_d    = GRANTED;
                    attempts_d = 3'(MAX_ATTEMPTS);
                end else begin
                    denied_d = 1'b1;
                    if (attempts_q <= 3'd1) begin
                        attempts_d = '0;
                        state_d    = LOCKOUT;
                        lockout_d  = 8'(LOCKOUT_SEC);
                    end else begin
                        attempts_d = attempts_q - 3'd1;
                        state_d    = IDLE;
                    end
                end
            end
            GRANTED: begin
                if (bus.set_pw && bus.new_password <= PW_MAX) begin
                    master_d = bus.new_password;
                end
                if (bus.logout) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (presc_q == PRESC_LAST) begin
                    if (lockout_q <= 8'd1) begin
                        lockout_d  = '0;
                        attempts_d = 3'(MAX_ATTEMPTS);
                        state_d    = IDLE;
                    end else begin
                        lockout_d = lockout_q - 8'd1;
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        unlocked_d = (state_d == GRANTED);
        locked_d   = (state_d == LOCKOUT);
    end

    // State and registered outputs, asynchronously reset
    always_ff @(posedge basys_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            master_q   <= 14'(DEFAULT_PW);
            guess_q    <= '0;
            pw_valid_q <= 1'b0;
            attempts_q <= 3'(MAX_ATTEMPTS);
            lockout_q  <= '0;
            presc_q    <= '0;
            unlocked_q <= 1'b0;
            denied_q   <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            master_q   <= master_d;
            guess_q    <= guess_d;
            pw_valid_q <= pw_valid_d;
            attempts_q <= attempts_d;
            lockout_q  <= lockout_d;
            presc_q    <= presc_d;
            unlocked_q <= unlocked_d;
            denied_q   <= denied_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.state             = state_q;
    assign bus.unlocked          = unlocked_q;
    assign bus.denied            = denied_q;
    assign bus.locked            = locked_q;
    assign bus.attempts_left     = attempts_q;
    assign bus.lockout_remaining = lockout_q;
    assign bus.pw_valid          = pw_valid_q;

endmodule

// File: tb/tb_password_access_ctrl.sv
// Testbench for password_access_ctrl: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural model.
module tb_password_access_ctrl;

    localparam int MAX_A = 3;
    localparam int LOCK_S = 3;
    localparam int TICKS = 4;

    logic basys_clk = 1'b0;
    logic reset = 1'b1;

    password_access_ctrl_if bus ();

    password_access_ctrl #(
        .MAX_ATTEMPTS (MAX_A),
        .LOCKOUT_SEC  (LOCK_S),
        .TICKS_PER_SEC(TICKS),
        .DEFAULT_PW   (0)
    ) dut (
        .basys_clk(basys_clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 basys_clk = ~basys_clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase code (0 idle, 1 check, 2 granted, 3 lockout)
    // and lockout tracked as a countdown of raw clock cycles.
    int m_phase, m_master, m_valid, m_pending, m_attempts, m_lock_cycles, m_denied;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_master = 0; m_valid = 0; m_pending = 0;
        m_attempts = MAX_A; m_lock_cycles = 0; m_denied = 0;
    endtask

    task automatic model_step(input int sp, input int np, input int sb, input int g, input int lo);
        m_denied = 0;
        case (m_phase)
            0: begin
                if (sp != 0) begin
                    if (m_valid == 0 && np <= 9999) begin
                        m_master = np;
                        m_valid = 1;
                    end
                end else if (sb != 0 && m_valid != 0) begin
                    m_pending = g;
                    m_phase = 1;
                end
            end
            1: begin
                if (m_pending <= 9999 && m_pending == m_master) begin
                    m_phase = 2;
                    m_attempts = MAX_A;
                end else begin
                    m_denied = 1;
                    m_attempts = m_attempts - 1;
                    if (m_attempts == 0) begin
                        m_phase = 3;
                        m_lock_cycles = LOCK_S * TICKS;
                    end else begin
                        m_phase = 0;
                    end
                end
            end
            2: begin
                if (sp != 0 && np <= 9999) m_master = np;
                if (lo != 0) m_phase = 0;
            end
            default: begin
                m_lock_cycles = m_lock_cycles - 1;
                if (m_lock_cycles == 0) begin
                    m_phase = 0;
                    m_attempts = MAX_A;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        int exp_rem;
        exp_rem = (m_phase == 3) ? (m_lock_cycles + TICKS - 1) / TICKS : 0;
        check_eq("state", int'(bus.state), m_phase);
        check_eq("unlocked", int'(bus.unlocked), (m_phase == 2) ? 1 : 0);
        check_eq("locked", int'(bus.locked), (m_phase == 3) ? 1 : 0);
        check_eq("denied", int'(bus.denied), m_denied);
        check_eq("attempts_left", int'(bus.attempts_left), m_attempts);
        check_eq("lockout_remaining", int'(bus.lockout_remaining), exp_rem);
        check_eq("pw_valid", int'(bus.pw_valid), m_valid);
    endtask

    // One clock cycle; called just after a falling edge.
    task automatic tick(input logic sp, input int np, input logic sb, input int g, input logic lo);
        bus.set_pw = sp;
        bus.new_password = 14'(np);
        bus.submit = sb;
        bus.guess = 14'(g);
        bus.logout = lo;
        @(posedge basys_clk);
        model_step(int'(sp), np, int'(sb), g, int'(lo));
        @(negedge basys_clk);
        bus.set_pw = 1'b0;
        bus.submit = 1'b0;
        bus.logout = 1'b0;
        compare_all();
    endtask

    task automatic idle();
        tick(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic try_guess(input int g);
        tick(1'b0, 0, 1'b1, g, 1'b0);
        idle();
    endtask

    // Asserts reset between edges and checks outputs before any clock edge.
    task automatic async_reset_mid_cycle();
        @(posedge basys_clk);
        model_step(0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check_eq("async_reset_locked", int'(bus.locked), 0);
        @(negedge basys_clk);
        reset = 1'b0;
        compare_all();
    endtask

    initial begin
        bus.set_pw = 1'b0;
        bus.new_password = '0;
        bus.submit = 1'b0;
        bus.guess = '0;
        bus.logout = 1'b0;
        model_reset();
        repeat (2) @(negedge basys_clk);
        compare_all();
        reset = 1'b0;

        // Guards before any password exists
        tick(1'b1, 12000, 1'b0, 0, 1'b0);
        check_eq("oversize_set_ignored", int'(bus.pw_valid), 0);
        tick(1'b0, 0, 1'b1, 1234, 1'b0);
        check_eq("submit_without_pw", int'(bus.state), 0);

        // Set then match, with two-edge latency
        tick(1'b1, 1234, 1'b0, 0, 1'b0);
        check_eq("pw_set", int'(bus.pw_valid), 1);
        tick(1'b0, 0, 1'b1, 1234, 1'b0);
        check_eq("check_phase", int'(bus.state), 1);
        idle();
        check_eq("grant_unlocked", int'(bus.unlocked), 1);
        check_eq("grant_attempts", int'(bus.attempts_left), 3);
        tick(1'b0, 0, 1'b0, 0, 1'b1);

        // Mismatch then recovery
        try_guess(1111);
        check_eq("mismatch_denied", int'(bus.denied), 1);
        check_eq("mismatch_attempts", int'(bus.attempts_left), 2);
        try_guess(1234);
        check_eq("recovery_granted", int'(bus.state), 2);
        tick(1'b0, 0, 1'b0, 0, 1'b1);

        // Lockout and expiry
        try_guess(1111);
        try_guess(1111);
        try_guess(1111);
        check_eq("lockout_entered", int'(bus.state), 3);
        check_eq("lockout_secs", int'(bus.lockout_remaining), 3);
        tick(1'b0, 0, 1'b1, 1234, 1'b0);
        repeat (10) idle();
        check_eq("lockout_before_expiry", int'(bus.state), 3);
        idle();
        check_eq("lockout_expired", int'(bus.state), 0);
        check_eq("attempts_reloaded", int'(bus.attempts_left), 3);

        // Password change while granted, combined with logout
        try_guess(1234);
        tick(1'b1, 42, 1'b0, 0, 1'b1);
        check_eq("change_logout_idle", int'(bus.state), 0);
        try_guess(1234);
        check_eq("old_pw_denied", int'(bus.denied), 1);
        try_guess(42);
        check_eq("new_pw_granted", int'(bus.unlocked), 1);
        tick(1'b0, 0, 1'b0, 0, 1'b1);

        // set_pw in IDLE once a password exists leaves master unchanged
        tick(1'b1, 5555, 1'b0, 0, 1'b0);
        try_guess(42);
        check_eq("master_kept", int'(bus.state), 2);
        tick(1'b0, 0, 1'b0, 0, 1'b1);

        // Async reset in the middle of a lockout
        try_guess(1);
        try_guess(2);
        try_guess(3);
        repeat (3) idle();
        async_reset_mid_cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic sp, sb, lo;
            int np, g, sel;
            sp = ($urandom_range(0, 7) == 0);
            np = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 9999))
                                             : int'($urandom_range(10000, 16383));
            sb = ($urandom_range(0, 2) == 0);
            sel = int'($urandom_range(0, 3));
            g = (sel < 2) ? m_master : (sel == 2) ? int'($urandom_range(0, 9999))
                                                  : int'($urandom_range(10000, 16383));
            lo = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 399) == 0) async_reset_mid_cycle();
            else tick(sp, np, sb, g, lo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
